// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and
// restoring divide share one 2*WIDTH accumulator, one bit per cycle.
module multdiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_next;

   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;
   logic               neg;
   logic               div_zero;

   logic               start;
   logic               finish;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_step, div_step;
   logic [2*WIDTH-1:0] prod;
   logic               mul_ovf;
   logic [WIDTH-1:0]   quot;
   logic               div_ovf;

   assign start = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
   assign finish = ((state == MUL) && (count == LAST)) ||
                   ((state == DIV) && (div_zero || (count == LAST)));
   assign busy = ((state == MUL) || (state == DIV)) && !div_zero;
   assign data_resultRDY = (state == DONE);

   always_comb begin
      mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

      // acc = {partial/remainder, multiplier/quotient}; operand is the fixed magnitude
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_ge    = (div_shift >= {1'b0, operand});
      div_diff  = div_shift - {1'b0, operand};
      div_step  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ge};

      prod    = neg ? -acc : acc;
      mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
      quot    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      // A positive quotient with its top bit set only arises from MIN / -1
      div_ovf = !neg && acc[WIDTH-1];
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = ctrl_MULT ? MUL : DIV;
         DONE: state_next = start ? (ctrl_MULT ? MUL : DIV) : IDLE;
         MUL,
         DIV:  if (finish) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count          <= '0;
         acc            <= '0;
         operand        <= '0;
         neg            <= 1'b0;
         div_zero       <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (start) begin
         count          <= '0;
         neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         data_result    <= '0;
         data_exception <= 1'b0;
         if (ctrl_MULT) begin
            acc      <= {{WIDTH{1'b0}}, mag_b};
            operand  <= mag_a;
            div_zero <= 1'b0;
         end else begin
            acc      <= {{WIDTH{1'b0}}, mag_a};
            operand  <= mag_b;
            div_zero <= (data_operandB == '0);
         end
      end else if (finish) begin
         if (state == MUL) begin
            data_result    <= prod[WIDTH-1:0];
            data_exception <= mul_ovf;
         end else if (div_zero || div_ovf) begin
            data_result    <= '0;
            data_exception <= 1'b1;
         end else begin
            data_result    <= quot;
            data_exception <= 1'b0;
         end
      end else if (state == MUL) begin
         acc   <= mul_step;
         count <= count + 1'b1;
      end else if (state == DIV) begin
         acc   <= div_step;
         count <= count + 1'b1;
      end
   end

endmodule
